// File: rtl/vga_scan_driver.sv
// 640x480@60 raster generator: pixel divider, scan counters and a registered colour/sync stage.
// Colour and sync lag the published scan coordinates by exactly one pixel.
module vga_scan_driver #(
   parameter int unsigned CLK_DIV     = 4,
   parameter logic [11:0] BG_COLOR    = 12'hFFF,
   parameter logic [11:0] GREY_COLOR  = 12'h555,
   parameter logic [11:0] WHITE_COLOR = 12'hFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inGrey,
   input  logic        inWhite,
   output logic [9:0]  vgaX,
   output logic [9:0]  vgaY,
   output logic        FrameClk,
   output logic        pixTick,
   output logic        vgaHs_n,
   output logic        vgaVs_n,
   output logic [11:0] vgaRGB
);

   localparam logic [7:0] DIV_LAST     = 8'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST       = 10'd799;
   localparam logic [9:0] H_VIS        = 10'd640;
   localparam logic [9:0] H_SYNC_START = 10'd656;
   localparam logic [9:0] H_SYNC_END   = 10'd751;
   localparam logic [9:0] V_LAST       = 10'd524;
   localparam logic [9:0] V_VIS        = 10'd480;
   localparam logic [9:0] V_SYNC_START = 10'd490;
   localparam logic [9:0] V_SYNC_END   = 10'd491;

   logic [7:0]  div_r;
   logic [9:0]  h_r;
   logic [9:0]  v_r;
   logic        hs_n_r;
   logic        vs_n_r;
   logic [11:0] rgb_r;

   logic        tick_s;
   logic        active_s;
   logic        hs_n_s;
   logic        vs_n_s;
   logic [11:0] rgb_s;
   logic [7:0]  div_nxt_s;
   logic [9:0]  h_nxt_s;
   logic [9:0]  v_nxt_s;

   // Divider and raster counter next-state; >= compares pull any stray value back to zero
   always_comb begin
      tick_s    = (div_r >= DIV_LAST);
      div_nxt_s = div_r;
      h_nxt_s   = h_r;
      v_nxt_s   = v_r;
      if (tick_s) begin
         div_nxt_s = 8'd0;
         if (h_r >= H_LAST) begin
            h_nxt_s = 10'd0;
            if (v_r >= V_LAST) begin
               v_nxt_s = 10'd0;
            end else begin
               v_nxt_s = v_r + 10'd1;
            end
         end else begin
            h_nxt_s = h_r + 10'd1;
            v_nxt_s = v_r;
         end
      end else begin
         div_nxt_s = div_r + 8'd1;
      end
   end

   // Colour and sync decode for the pixel currently being scanned
   always_comb begin
      active_s = (h_r < H_VIS) && (v_r < V_VIS);
      hs_n_s   = !((h_r >= H_SYNC_START) && (h_r <= H_SYNC_END));
      vs_n_s   = !((v_r >= V_SYNC_START) && (v_r <= V_SYNC_END));
      rgb_s    = 12'h000;
      if (!active_s) begin
         rgb_s = 12'h000;
      end else if (inGrey) begin
         rgb_s = GREY_COLOR;
      end else if (inWhite) begin
         rgb_s = WHITE_COLOR;
      end else begin
         rgb_s = BG_COLOR;
      end
   end

   // Counter state and output registers; outputs only move on a pixel tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_r  <= 8'd0;
         h_r    <= 10'd0;
         v_r    <= 10'd0;
         hs_n_r <= 1'b1;
         vs_n_r <= 1'b1;
         rgb_r  <= 12'h000;
      end else begin
         div_r <= div_nxt_s;
         h_r   <= h_nxt_s;
         v_r   <= v_nxt_s;
         if (tick_s) begin
            hs_n_r <= hs_n_s;
            vs_n_r <= vs_n_s;
            rgb_r  <= rgb_s;
         end else begin
            hs_n_r <= hs_n_r;
            vs_n_r <= vs_n_r;
            rgb_r  <= rgb_r;
         end
      end
   end

   assign vgaX     = h_r;
   assign vgaY     = v_r;
   assign FrameClk = (v_r >= V_VIS);
   assign pixTick  = tick_s;
   assign vgaHs_n  = hs_n_r;
   assign vgaVs_n  = vs_n_r;
   assign vgaRGB   = rgb_r;

endmodule

// File: doc/vga_scan_driver.md
# vga_scan_driver

Display-side counterpart of the background/sprite drawing delegates. Generates 640x480@60 raster timing from the system clock, publishes the scan coordinates (`vgaX`, `vgaY`) and the once-per-frame `FrameClk` that delegates consume, then takes the delegates' `inGrey`/`inWhite` pixel flags back and turns them into registered RGB plus sync signals aligned for the VGA connector.

## Interface
- `CLK_DIV`, 4: system clocks per pixel; legal 1..255 (4 gives 25 MHz pixels from 100 MHz).
- `BG_COLOR`, 12'hFFF: RGB444 colour when no flag is set in the active area.
- `GREY_COLOR`, 12'h555: RGB444 colour for `inGrey`.
- `WHITE_COLOR`, 12'hFFF: RGB444 colour for `inWhite`.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `inGrey` in 1: delegate flag for current `vgaX`/`vgaY`, combinational from the outputs below.
- `inWhite` in 1: delegate flag for current `vgaX`/`vgaY`.
- `vgaX` out 10: horizontal counter, 0..799.
- `vgaY` out 10: vertical counter, 0..524.
- `FrameClk` out 1: high while `vgaY` >= 480 (vertical blank).
- `pixTick` out 1: one-`clk` pulse per pixel.
- `vgaHs_n` out 1: horizontal sync, active low, registered.
- `vgaVs_n` out 1: vertical sync, active low, registered.
- `vgaRGB` out 12: {R[3:0],G[3:0],B[3:0]}, registered.

## Operation
- Divider: 8-bit `div` counts 0..CLK_DIV-1 on every `clk`, then wraps to 0. `pixTick` = (`div` == CLK_DIV-1). With CLK_DIV=1, `pixTick` is constantly 1 after reset.
- Horizontal counter advances only on `pixTick`: 0..799, then wraps to 0.
- Vertical counter increments when H wraps (799 -> 0): 0..524, then wraps to 0.
- Timing regions:
  - H: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
  - V: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
- `active` = (H < 640) && (V < 480).
- `FrameClk` is combinational from the V counter (V >= 480). It rises exactly once per frame, at the `pixTick` taking (799,479) -> (0,480), and falls at (799,524) -> (0,0). Delegates update their state during the 45 blank lines.
- Output stage updates on each `pixTick`, using current counters and flags:
  - `vgaHs_n` <= !(656 <= H <= 751).
  - `vgaVs_n` <= !(490 <= V <= 491).
  - `vgaRGB` <= 0 if !active; else GREY_COLOR if `inGrey` (grey wins when both flags are set); else WHITE_COLOR if `inWhite`; else BG_COLOR.
- All arithmetic is unsigned. Counter compares use full 10-bit width. No counter may exceed its terminal value.

## Timing
- Reset values: `div`=0, `vgaX`=0, `vgaY`=0, `FrameClk`=0, `pixTick`=0 (CLK_DIV>1), `vgaHs_n`=1, `vgaVs_n`=1, `vgaRGB`=0.
- First `pixTick` occurs CLK_DIV-1 `clk` rising edges after `rst` deasserts.
- Delegate flags must settle within one `clk` period of a counter change. They are sampled on the next `pixTick`.
- Latency: `vgaRGB`, `vgaHs_n` and `vgaVs_n` lag `vgaX`/`vgaY` by exactly one pixel. Sync and colour are mutually aligned.
- Between ticks, all registered outputs hold their values.
- Pulse widths:
  - `vgaHs_n` low for 96 pixels per line.
  - `vgaVs_n` low for 1600 pixels (2 lines) per frame.
  - Frame = 420,000 pixels.
- Reset mid-frame: all state returns to reset values asynchronously. Counting restarts from (0,0) with no partial sync pulse retained.

## Test plan
- Reset then release, CLK_DIV=4 -> all outputs at reset values. First `pixTick` 3 clocks after release. `vgaX`=1 after that tick.
- Run one line -> `vgaHs_n` low for exactly 384 `clk` cycles, first low one pixel after `vgaX`=656. `vgaX` wraps 799 -> 0 with `vgaY` +1.
- Run one full frame -> `FrameClk` rises once, at (0,480), and stays high 45x800 pixels. `vgaVs_n` low for 2 lines. Counters return to (0,0) after 420,000 ticks.
- Drive flag pairs at (10,10) -> `vgaRGB` one pixel later:
  - (1,0) gives 12'h555.
  - (1,1) gives 12'h555.
  - (0,1) gives 12'hFFF.
  - (0,0) gives BG_COLOR.
  - Force `inGrey`=1 at (700,10) -> `vgaRGB`=0.
- Assert `rst` for 1 clk at (400,300) -> immediate reset values. Restart at (0,0), with the first `vgaHs_n` low after 656 more pixels.
- CLK_DIV=1 build -> `pixTick` constant 1. Counters advance every `clk`. Line = 800 clocks.
